// File: rtl/key_schedule_pkg.sv
// key_schedule_pkg
//   Shared definitions for the key schedule block: FSM state encoding, the
//   default round count, and round_key_f. round_key_f is the one definition
//   of the 64-to-32 round-key mixing function. The round_key datapath module
//   evaluates it, and the testbench calls it as the reference.
package key_schedule_pkg;

  localparam int NUM_ROUNDS_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_EXPAND = 2'b01,
    ST_DONE   = 2'b10
  } ks_state_e;

  // Additive constant. It keeps an all-zero key from producing all-zero round keys.
  localparam logic [31:0] RK_CONST = 32'h9E37_79B9;

  // x = {a, b}.  F = (rotl(a,5) + b) ^ rotl(b,13) ^ RK_CONST
  function automatic logic [31:0] round_key_f(input logic [63:0] x);
    logic [31:0] a;
    logic [31:0] b;
    a = x[63:32];
    b = x[31:0];
    return ({a[26:0], a[31:27]} + b) ^ {b[18:0], b[31:19]} ^ RK_CONST;
  endfunction

endpackage

// File: rtl/key_schedule_round_key.sv
// round_key
//   Combinational 64-bit to 32-bit round-key mixing function.
//   Ports:
//     din   in  64  {w0, w1 ^ idx} from the key state
//     dout  out 32  round key
module round_key
  import key_schedule_pkg::*;
(
  input  logic [63:0] din,
  output logic [31:0] dout
);

  assign dout = round_key_f(din);

endmodule

// File: rtl/key_schedule.sv
// key_schedule
//   Expands a 128-bit master key into NUM_ROUNDS 32-bit round keys.
//   The keys are streamed over a valid/ready interface and copied into a
//   readable buffer.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     key_valid/key_ready   master key handshake, key_data = {w0,w1,w2,w3}
//     clear                 synchronous abort back to IDLE
//     rk_valid/rk_ready     round key handshake, rk_data / rk_idx
//     done                  level, all round keys generated and buffered
//     rd_en/rd_idx/rd_data  buffer read port, 1-cycle latency
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for a master key; buffer contents are not valid
//   ST_EXPAND | presenting round key idx; advances on each rk handshake
//   ST_DONE   | all round keys buffered; a new key restarts expansion
module key_schedule
  import key_schedule_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEFAULT,
  parameter int IDX_W      = $clog2(NUM_ROUNDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [127:0]     key_data,
  input  logic             clear,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [31:0]      rk_data,
  output logic [IDX_W-1:0] rk_idx,
  output logic             done,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  // Buffer address width. IDX_W may be wider than the buffer needs.
  localparam int              BUF_AW   = $clog2(NUM_ROUNDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);
  localparam logic [IDX_W:0]   NR_W     = (IDX_W + 1)'(NUM_ROUNDS);

  ks_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [127:0]     k_q;
  logic [31:0]      rd_data_q;
  logic [31:0]      buf_q [NUM_ROUNDS];

  logic        key_hs;
  logic        rk_hs;
  logic        last_idx;
  logic        rd_in_range;
  logic [63:0] rk_in;
  logic [31:0] rk_out;

  assign rk_in = {k_q[127:96], k_q[95:64] ^ 32'(idx_q)};

  round_key u_round_key (
    .din  (rk_in),
    .dout (rk_out)
  );

  assign key_hs      = key_valid & key_ready;
  assign rk_hs       = rk_valid & rk_ready;
  assign last_idx    = (idx_q == LAST_IDX);
  assign rd_in_range = ({1'b0, rd_idx} < NR_W);

  assign rk_data = rk_out;
  assign rk_idx  = idx_q;
  assign rd_data = rd_data_q;

  always_comb begin
    state_d   = state_q;
    key_ready = 1'b0;
    rk_valid  = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        key_ready = 1'b1;
        if (key_valid) state_d = ST_EXPAND;
      end
      ST_EXPAND: begin
        rk_valid = 1'b1;
        if (rk_ready && last_idx) state_d = ST_DONE;
      end
      ST_DONE: begin
        key_ready = 1'b1;
        done      = 1'b1;
        if (key_valid) state_d = ST_EXPAND;
      end
      default: state_d = ST_IDLE;
    endcase
    // clear wins over any handshake in flight
    if (clear) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      k_q       <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (key_hs && !clear) begin
        k_q   <= key_data;
        idx_q <= '0;
      end else if (rk_hs) begin
        k_q <= {k_q[95:0], rk_out ^ k_q[127:96]};
        // idx parks on the last entry; the next key load zeroes it
        if (!last_idx) idx_q <= idx_q + IDX_W'(1);
      end
      if (rd_en) rd_data_q <= rd_in_range ? buf_q[rd_idx[BUF_AW-1:0]] : '0;
    end
  end

  // Buffer storage is not reset. done = 0 marks the contents stale.
  // A read in the same cycle as a write to that entry returns the old value.
  always_ff @(posedge clk) begin
    if (!rst && rk_hs) buf_q[idx_q[BUF_AW-1:0]] <= rk_out;
  end

endmodule

// File: tb/tb_key_schedule.sv
module tb_key_schedule;
  import key_schedule_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-round instance
  logic         rst, key_valid, clear, rk_ready, rd_en;
  logic [127:0] key_data;
  logic [2:0]   rd_idx;
  logic         key_ready, rk_valid, done;
  logic [31:0]  rk_data, rd_data;
  logic [2:0]   rk_idx;

  key_schedule #(.NUM_ROUNDS(8)) u_dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
    .key_data(key_data), .clear(clear), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_idx(rk_idx), .done(done), .rd_en(rd_en),
    .rd_idx(rd_idx), .rd_data(rd_data)
  );

  // 2-round instance with a wide index, so out-of-range reads can be reached
  logic         rst_2, key_valid_2, clear_2, rk_ready_2, rd_en_2;
  logic [127:0] key_data_2;
  logic [3:0]   rd_idx_2;
  logic         key_ready_2, rk_valid_2, done_2;
  logic [31:0]  rk_data_2, rd_data_2;
  logic [3:0]   rk_idx_2;

  key_schedule #(.NUM_ROUNDS(2), .IDX_W(4)) u_dut2 (
    .clk(clk), .rst(rst_2), .key_valid(key_valid_2), .key_ready(key_ready_2),
    .key_data(key_data_2), .clear(clear_2), .rk_valid(rk_valid_2), .rk_ready(rk_ready_2),
    .rk_data(rk_data_2), .rk_idx(rk_idx_2), .done(done_2), .rd_en(rd_en_2),
    .rd_idx(rd_idx_2), .rd_data(rd_data_2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Round key i of a master key, recomputed from scratch by walking the schedule
  function automatic logic [31:0] rk_at(input logic [127:0] key, input int i);
    logic [31:0] w0, w1, w2, w3, r;
    {w0, w1, w2, w3} = key;
    r = '0;
    for (int j = 0; j <= i; j++) begin
      r = round_key_f({w0, w1 ^ 32'(j)});
      {w0, w1, w2, w3} = {w1, w2, w3, r ^ w0};
    end
    return r;
  endfunction

  // Transaction-level model of the 8-round instance
  bit           m_live = 1'b0;
  bit           m_busy, m_done, m_rd_known;
  int           m_cnt;
  logic [127:0] m_key;
  logic [31:0]  m_rd;
  logic [31:0]  m_buf [8];
  bit           m_bv  [8];

  initial for (int i = 0; i < 8; i++) m_bv[i] = 1'b0;

  always @(negedge clk) begin : cmp
    bit busy0;
    if (m_live) begin
      chk("key_ready", 32'(key_ready), 32'(!m_busy));
      chk("rk_valid", 32'(rk_valid), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      if (m_busy) begin
        chk("rk_idx", 32'(rk_idx), 32'(m_cnt));
        chk("rk_data", rk_data, rk_at(m_key, m_cnt));
      end
      if (m_rd_known) chk("rd_data", rd_data, m_rd);
    end
    busy0 = m_busy;
    if (rst) begin
      m_live = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
      m_rd = '0; m_rd_known = 1'b1;
    end else if (m_live) begin
      if (rd_en) begin
        m_rd_known = m_bv[rd_idx];
        m_rd       = m_buf[rd_idx];
      end
      if (busy0 && rk_ready) begin
        m_buf[m_cnt] = rk_at(m_key, m_cnt);
        m_bv[m_cnt]  = 1'b1;
        if (m_cnt == 7) begin m_busy = 1'b0; m_done = 1'b1; end
        else m_cnt++;
      end
      if (clear) begin
        m_busy = 1'b0; m_done = 1'b0;
      end else if (!busy0 && key_valid) begin
        m_key = key_data; m_cnt = 0; m_busy = 1'b1; m_done = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_valid = 1'b1; key_data = k;
    cyc();
    key_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic [63:0] v;
    logic [127:0] kc;

    rst = 1'b1; key_valid = 1'b1; key_data = 128'hDEAD; clear = 1'b0;
    rk_ready = 1'b0; rd_en = 1'b0; rd_idx = '0;
    rst_2 = 1'b1; key_valid_2 = 1'b0; key_data_2 = '0; clear_2 = 1'b0;
    rk_ready_2 = 1'b0; rd_en_2 = 1'b0; rd_idx_2 = '0;
    repeat (3) cyc();
    rst = 1'b0; key_valid = 1'b0;
    cyc();
    chk("rst_key_ready", 32'(key_ready), 32'd1);
    chk("rst_rd_data", rd_data, 32'd0);

    // hand-computed values pinning the reference function
    v = 64'h0;                   chk("pin_f_zero", round_key_f(v), 32'h9E3779B9);
    v = 64'h00000001_00000000;   chk("pin_f_a1", round_key_f(v), 32'h9E377999);
    v = 64'h00000000_00000001;   chk("pin_f_b1", round_key_f(v), 32'h9E3759B8);

    // all-zero key, rk_ready held high
    rk_ready = 1'b1;
    load_key(128'h0);
    chk("pin_rk0", rk_data, 32'h9E3779B9);
    chk("pin_idx0", 32'(rk_idx), 32'd0);
    cyc();
    chk("pin_rk1", rk_data, 32'h9E3759B8);
    n = 1;
    while (!done && n < 40) begin cyc(); n++; end
    chk("zero_key_cycles", 32'(n), 32'd8);
    rk_ready = 1'b0;

    // buffer read-back
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1; rd_idx = 3'(i);
      cyc();
      if (i == 0) chk("pin_rd0", rd_data, 32'h9E3779B9);
    end
    rd_en = 1'b0;
    cyc(); cyc();

    // restart from DONE, rk_ready toggling
    load_key(128'h0123456789ABCDEF_FEDCBA9876543210);
    rk_ready = 1'b1; n = 0;
    while (!done && n < 40) begin cyc(); n++; rk_ready = ~rk_ready; end
    chk("toggle_cycles", 32'(n), 32'd15);
    rk_ready = 1'b0;

    // clear at idx 3, then reload the same key
    kc = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    rk_ready = 1'b1;
    load_key(kc);
    n = 0;
    while (rk_idx != 3'd3 && n < 20) begin cyc(); n++; end
    chk("reach_idx3", 32'(rk_idx), 32'd3);
    rk_ready = 1'b0; clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clear_rk_valid", 32'(rk_valid), 32'd0);
    chk("clear_done", 32'(done), 32'd0);
    rk_ready = 1'b1;
    load_key(kc);
    chk("reload_idx0", 32'(rk_idx), 32'd0);
    n = 0;
    while (!done && n < 40) begin cyc(); n++; end
    chk("reload_cycles", 32'(n), 32'd8);

    // reset at idx 5 with key_valid held through reset
    load_key(128'h1111_2222_3333_4444_5555_6666_7777_8888);
    n = 0;
    while (rk_idx != 3'd5 && n < 20) begin cyc(); n++; end
    chk("reach_idx5", 32'(rk_idx), 32'd5);
    rst = 1'b1; key_valid = 1'b1; key_data = 128'hABCD;
    cyc();
    chk("rst_mid_rk_valid", 32'(rk_valid), 32'd0);
    chk("rst_mid_idx", 32'(rk_idx), 32'd0);
    chk("rst_mid_rd_data", rd_data, 32'd0);
    cyc();
    rst = 1'b0; key_valid = 1'b0;
    cyc();
    chk("rst_no_accept", 32'(rk_valid), 32'd0);
    chk("rst_key_ready2", 32'(key_ready), 32'd1);
    rk_ready = 1'b0;

    // 2-round instance: stream, out-of-range reads, restart from DONE
    rst_2 = 1'b0;
    cyc();
    chk("d2_rst_done", 32'(done_2), 32'd0);
    chk("d2_rst_rd", rd_data_2, 32'd0);
    rk_ready_2 = 1'b1; key_valid_2 = 1'b1;
    key_data_2 = 128'hA5A5A5A5_5A5A5A5A_00FF00FF_FF00FF00;
    cyc();
    key_valid_2 = 1'b0;
    chk("d2_a_idx0", 32'(rk_idx_2), 32'd0);
    chk("d2_a_rk0", rk_data_2, rk_at(128'hA5A5A5A5_5A5A5A5A_00FF00FF_FF00FF00, 0));
    cyc();
    chk("d2_a_idx1", 32'(rk_idx_2), 32'd1);
    chk("d2_a_rk1", rk_data_2, rk_at(128'hA5A5A5A5_5A5A5A5A_00FF00FF_FF00FF00, 1));
    cyc();
    rk_ready_2 = 1'b0;
    chk("d2_a_done", 32'(done_2), 32'd1);
    chk("d2_a_rkv", 32'(rk_valid_2), 32'd0);
    rd_en_2 = 1'b1; rd_idx_2 = 4'd15;
    cyc();
    chk("d2_rd15", rd_data_2, 32'd0);
    rd_idx_2 = 4'd1;
    cyc();
    chk("d2_rd1", rd_data_2, rk_at(128'hA5A5A5A5_5A5A5A5A_00FF00FF_FF00FF00, 1));
    rd_idx_2 = 4'd2;
    cyc();
    chk("d2_rd2", rd_data_2, 32'd0);
    rd_idx_2 = 4'd0;
    cyc();
    rd_en_2 = 1'b0;
    cyc();
    chk("d2_rd_hold", rd_data_2, rk_at(128'hA5A5A5A5_5A5A5A5A_00FF00FF_FF00FF00, 0));
    key_valid_2 = 1'b1; key_data_2 = 128'h13579BDF_2468ACE0_FEEDFACE_CAFEBABE;
    cyc();
    key_valid_2 = 1'b0;
    chk("d2_b_done_drop", 32'(done_2), 32'd0);
    chk("d2_b_rk0", rk_data_2, rk_at(128'h13579BDF_2468ACE0_FEEDFACE_CAFEBABE, 0));
    cyc();
    chk("d2_b_stall", rk_data_2, rk_at(128'h13579BDF_2468ACE0_FEEDFACE_CAFEBABE, 0));
    rk_ready_2 = 1'b1; rd_en_2 = 1'b1; rd_idx_2 = 4'd0;
    cyc();
    rd_en_2 = 1'b0;
    chk("d2_rw_old", rd_data_2, rk_at(128'hA5A5A5A5_5A5A5A5A_00FF00FF_FF00FF00, 0));
    chk("d2_b_rk1", rk_data_2, rk_at(128'h13579BDF_2468ACE0_FEEDFACE_CAFEBABE, 1));
    cyc();
    rk_ready_2 = 1'b0;
    chk("d2_b_done", 32'(done_2), 32'd1);
    rd_en_2 = 1'b1; rd_idx_2 = 4'd0;
    cyc();
    chk("d2_b_rd0", rd_data_2, rk_at(128'h13579BDF_2468ACE0_FEEDFACE_CAFEBABE, 0));
    rd_idx_2 = 4'd1;
    cyc();
    rd_en_2 = 1'b0;
    chk("d2_b_rd1", rd_data_2, rk_at(128'h13579BDF_2468ACE0_FEEDFACE_CAFEBABE, 1));

    // randomized traffic on the 8-round instance
    for (int c = 0; c < 800; c++) begin
      key_valid = ($urandom_range(0, 3) == 0);
      key_data  = {$urandom, $urandom, $urandom, $urandom};
      rk_ready  = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 149) == 0);
      rd_en     = ($urandom_range(0, 1) == 0);
      rd_idx    = 3'($urandom_range(0, 7));
      cyc();
    end
    rst = 1'b0; key_valid = 1'b0; clear = 1'b0; rd_en = 1'b0; rk_ready = 1'b0;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_schedule.md
KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 Parameter NUM_ROUNDS, default 8, round keys generated per master key, legal range 2..16.
REQ-002 Parameter IDX_W, default $clog2(NUM_ROUNDS), width of round index.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset is synchronous and active-high.
REQ-005 key_valid  in  1  master key offered.
REQ-006 key_ready  out  1  block accepts a master key.
REQ-007 key_data  in  128  master key {w0,w1,w2,w3}, w0 = bits 127:96.
REQ-008 clear  in  1  synchronous abort; returns block to IDLE.
REQ-009 rk_valid  out  1  round key available.
REQ-010 rk_ready  in  1  downstream accepts round key.
REQ-011 rk_data  out  32  current round key.
REQ-012 rk_idx  out  IDX_W  index of current round key.
REQ-013 done  out  1  level; all NUM_ROUNDS keys generated and buffered.
REQ-014 rd_en  in  1  buffer read request.
REQ-015 rd_idx  in  IDX_W  buffer read address.
REQ-016 rd_data  out  32  buffer read data, 1-cycle latency.

Function
REQ-017 FSM states IDLE, EXPAND, DONE; encoding is fixed by the shared package.
REQ-018 key_ready SHALL be 1 in IDLE and DONE and 0 in EXPAND.
REQ-019 Key handshake (key_valid & key_ready) SHALL latch key_data into state register K, zero idx, clear done, and go to EXPAND next cycle.
REQ-020 In EXPAND, rk_valid SHALL be 1, rk_idx = idx, and rk_data = F({w0, w1 ^ {{(32-IDX_W){0}}, idx}}), where F is the 64-to-32 round_key function.
REQ-021 rk_data and rk_idx SHALL hold stable while rk_valid & !rk_ready.
REQ-022 On rk handshake, buffer[idx] <= rk_data, K <= {w1, w2, w3, rk_data ^ w0}, idx <= idx+1.
REQ-023 On the handshake with idx = NUM_ROUNDS-1, go to DONE; idx does not wrap.
REQ-024 Throughput: one round key per cycle when rk_ready is held high; first rk_valid appears 1 cycle after key handshake.
REQ-025 done SHALL be 1 only in DONE.
REQ-026 A key handshake in DONE SHALL restart expansion; old buffer contents remain readable until overwritten.
REQ-027 clear SHALL force IDLE next cycle from any state, deassert rk_valid and done; buffer contents are not erased. clear has priority over a concurrent key handshake.
REQ-028 rd_data <= buffer[rd_idx] on the cycle after rd_en; rd_idx >= NUM_ROUNDS returns 0; rd_data holds when rd_en = 0.
REQ-029 A read and a write to the same entry in one cycle SHALL return the old value.

Reset
REQ-030 rst SHALL force IDLE, idx = 0, K = 0, rk_valid = 0, done = 0, rd_data = 0, key_ready = 1 on the cycle after reset; rst has priority over clear and all handshakes.
REQ-031 Buffer contents need not be reset; done = 0 marks them invalid.
REQ-032 rst asserted mid-EXPAND SHALL abandon the expansion with no further rk handshakes.

Structure
REQ-033 Package key_schedule_pkg SHALL hold the state enum, NUM_ROUNDS default, and a reference function round_key_f used by the bench.
REQ-034 The only sub-module SHALL be one instance of round_key (64-bit in, 32-bit out, combinational); no other arithmetic is duplicated.
REQ-035 The buffer is an NUM_ROUNDS x 32 register array with one write port and one read port.

Verification
REQ-036 Key 128'h0 with rk_ready = 1 -> rk_idx 0..7 on 8 consecutive cycles, done = 1 on cycle 9, values equal to the package model.
REQ-037 Key 128'h0123456789ABCDEF_FEDCBA9876543210 with rk_ready toggling 1/0 -> 8 keys over 16 cycles, rk_data stable during stalls, sequence matches the model.
REQ-038 clear asserted at idx = 3 -> IDLE next cycle, rk_valid = 0, done = 0; reload of the same key gives the full sequence from idx 0.
REQ-039 After done, rd_en with rd_idx = 0..7 -> rd_data equals the streamed keys one cycle later; rd_idx = 15 -> 0.
REQ-040 rst at idx = 5 -> outputs at reset values next cycle; key_valid held during rst is not accepted.
REQ-041 New key handshake in DONE with NUM_ROUNDS = 2 -> done drops next cycle, 2 new keys stream, buffer overwritten.
